// File: rtl/inst_fetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue between a 1-cycle synchronous
// instruction memory and ID. Redirect or reset flushes queued and in-flight fetches.
module inst_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_i,
    input  logic [XLEN-1:0]         redirect_pc_i,
    input  logic                    id_ready_i,
    output logic                    id_valid_o,
    output logic [XLEN-1:0]         id_pc_o,
    output logic [XLEN-1:0]         id_pc_plus4_o,
    output logic [31:0]             id_inst_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Fetch-side state
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] inflight_pc_reg;
    logic            inflight_reg;

    // Queue-side state
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] pc4_mem  [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic            flush;
    logic            pop;
    logic            wr_en;
    logic            head_valid;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] redirect_pc_aligned;

    assign flush               = reset | redirect_i;
    assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);
    assign head_valid          = (count_reg != '0);

    assign id_valid_o = head_valid & !flush;
    assign pop        = id_valid_o & id_ready_i;

    // Occupancy after this cycle's pop plus the word already on its way must
    // leave room for the word this request will return.
    assign credit_sum = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign imem_req   = !flush & (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc_reg;

    // A response whose cycle coincides with a flush is dropped (kill).
    assign wr_en = inflight_reg & !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            inflight_reg <= imem_req;
            if (imem_req) begin
                inflight_pc_reg <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + XLEN'(4);
            end
            if (redirect_i) begin
                fetch_pc_reg <= redirect_pc_aligned;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Storage is read asynchronously so a word written at the end of one
    // cycle is at the head in the very next cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
            pc4_mem[wr_ptr_reg]  <= inflight_pc_reg + XLEN'(4);
            inst_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

    assign id_pc_o       = head_valid ? pc_mem[rd_ptr_reg]   : '0;
    assign id_pc_plus4_o = head_valid ? pc4_mem[rd_ptr_reg]  : '0;
    assign id_inst_o     = head_valid ? inst_mem[rd_ptr_reg] : '0;
    assign count_o       = count_reg;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en && count_reg == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && count_reg == '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed latency/flush scenarios plus
// a randomized run against a PC-sequence reference model.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;

    logic        imem_req,   w_imem_req;
    logic [31:0] imem_addr,  w_imem_addr;
    logic [31:0] imem_rdata, w_imem_rdata;
    logic        id_valid_o, w_id_valid_o;
    logic [31:0] id_pc_o,    w_id_pc_o;
    logic [31:0] id_pc_plus4_o, w_id_pc_plus4_o;
    logic [31:0] id_inst_o,  w_id_inst_o;
    logic [2:0]  count_o,    w_count_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .id_ready_i(id_ready_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o),
        .id_inst_o(id_inst_o), .count_o(count_o)
    );

    inst_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .id_ready_i(id_ready_i),
        .id_valid_o(w_id_valid_o), .id_pc_o(w_id_pc_o), .id_pc_plus4_o(w_id_pc_plus4_o),
        .id_inst_o(w_id_inst_o), .count_o(w_count_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    // 1-cycle synchronous instruction memories
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= mem_word(imem_addr);
        if (w_imem_req) w_imem_rdata <= mem_word(w_imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = rdy;
        tick(); tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", id_valid_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_cmp++; if (id_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", id_pc_o); end
        n_cmp++; if (id_pc_plus4_o !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h want 0", id_pc_plus4_o); end
        n_cmp++; if (id_inst_o !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", id_inst_o); end
        reset = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_req: got %0b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL release_addr: got %h want 0", imem_addr); end
        $display("test_reset: checked reset outputs and first request");
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        do_reset(1'b1);
        for (int c = 0; c < 8; c++) begin
            #1;
            epc = 32'(4 * (c - 2));
            if (c < 2) begin
                n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_early_valid c%0d: got %0b want 0", c, id_valid_o); end
            end else begin
                n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid c%0d: got %0b want 1", c, id_valid_o); end
                n_cmp++; if (id_pc_o !== epc) begin n_err++; $display("FAIL stream_pc c%0d: got %h want %h", c, id_pc_o, epc); end
                n_cmp++; if (id_pc_plus4_o !== epc + 32'd4) begin n_err++; $display("FAIL stream_pc4 c%0d: got %h want %h", c, id_pc_plus4_o, epc + 32'd4); end
                n_cmp++; if (id_inst_o !== mem_word(epc)) begin n_err++; $display("FAIL stream_inst c%0d: got %h want %h", c, id_inst_o, mem_word(epc)); end
            end
            tick();
        end
        $display("test_stream: pcs 0,4,8,... from cycle 2");
    endtask

    task automatic test_stall();
        logic [31:0] epc;
        do_reset(1'b0);
        repeat (8) tick();
        #1;
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL stall_count: got %0d want 4", count_o); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req: got %0b want 0", imem_req); end
        n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %0b want 1", id_valid_o); end
        n_cmp++; if (id_pc_o !== 32'h0) begin n_err++; $display("FAIL stall_head: got %h want 0", id_pc_o); end
        id_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            epc = 32'(4 * k);
            n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid k%0d: got %0b want 1", k, id_valid_o); end
            n_cmp++; if (id_pc_o !== epc) begin n_err++; $display("FAIL drain_pc k%0d: got %h want %h", k, id_pc_o, epc); end
            tick();
        end
        $display("test_stall: filled to 4, drained without gaps");
    endtask

    task automatic test_redirect();
        logic [31:0] epc;
        do_reset(1'b0);
        repeat (4) tick();
        #1;
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL redir_precount: got %0d want 3", count_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        #1;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %0b want 0", id_valid_o); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %0b want 0", imem_req); end
        tick();
        redirect_i = 1'b0; id_ready_i = 1'b1;
        #1;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL redir_count: got %0d want 0", count_o); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr: got %h want 100", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL redir_req1: got %0b want 1", imem_req); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_r1_valid: got %0b want 0", id_valid_o); end
        for (int k = 2; k < 8; k++) begin
            tick();
            #1;
            if (k == 2) begin
                n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_r2_valid: got %0b want 0", id_valid_o); end
            end else begin
                epc = 32'h100 + 32'(4 * (k - 3));
                n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL redir_new_valid r%0d: got %0b want 1", k, id_valid_o); end
                n_cmp++; if (id_pc_o !== epc) begin n_err++; $display("FAIL redir_new_pc r%0d: got %h want %h", k, id_pc_o, epc); end
            end
        end
        $display("test_redirect: flush to 0x100, first pc at r+3");
    endtask

    task automatic test_redirect_align();
        do_reset(1'b1);
        repeat (4) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        #1;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL align_valid: got %0b want 0", id_valid_o); end
        tick();
        redirect_i = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL align_addr: got %h want 100", imem_addr); end
        tick(); tick();
        #1;
        n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL align_id_valid: got %0b want 1", id_valid_o); end
        n_cmp++; if (id_pc_o !== 32'h100) begin n_err++; $display("FAIL align_pc: got %h want 100", id_pc_o); end
        n_cmp++; if (id_inst_o !== mem_word(32'h100)) begin n_err++; $display("FAIL align_inst: got %h want %h", id_inst_o, mem_word(32'h100)); end
        $display("test_redirect_align: 0x103 fetched as 0x100");
    endtask

    task automatic test_reset_inflight();
        do_reset(1'b1);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %0b want 0", imem_req); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid1: got %0b want 0", id_valid_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count_o); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_addr: got %h want 0", imem_addr); end
        tick();
        #1;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid2: got %0b want 0", id_valid_o); end
        tick();
        #1;
        n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_valid3: got %0b want 1", id_valid_o); end
        n_cmp++; if (id_pc_o !== 32'h0) begin n_err++; $display("FAIL rstmid_pc: got %h want 0", id_pc_o); end
        $display("test_reset_inflight: in-flight word dropped, restart at RESET_PC");
    endtask

    task automatic test_wrap();
        logic [31:0] epc;
        do_reset(1'b1);
        for (int c = 0; c < 6; c++) begin
            #1;
            epc = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
            if (c >= 2) begin
                n_cmp++; if (w_id_valid_o !== 1'b1) begin n_err++; $display("FAIL wrap_valid c%0d: got %0b want 1", c, w_id_valid_o); end
                n_cmp++; if (w_id_pc_o !== epc) begin n_err++; $display("FAIL wrap_pc c%0d: got %h want %h", c, w_id_pc_o, epc); end
                n_cmp++; if (w_id_pc_plus4_o !== epc + 32'd4) begin n_err++; $display("FAIL wrap_pc4 c%0d: got %h want %h", c, w_id_pc_plus4_o, epc + 32'd4); end
                n_cmp++; if (w_id_inst_o !== mem_word(epc)) begin n_err++; $display("FAIL wrap_inst c%0d: got %h want %h", c, w_id_inst_o, mem_word(epc)); end
            end
            tick();
        end
        $display("test_wrap: FFFF_FFF8 -> FFFF_FFFC -> 0000_0000");
    endtask

    // Reference: ID must see an unbroken +4 PC sequence restarting at each
    // aligned redirect target, never within 2 cycles of a redirect, and never
    // starve for more than 3 cycles.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          since_redir;
        int          quiet;
        int          n_pop;
        do_reset(1'b1);
        exp_pc = 32'h0; since_redir = 1; quiet = 0; n_pop = 0;
        for (int n = 0; n < 1500; n++) begin
            id_ready_i = ($urandom_range(0, 3) != 0);
            redirect_i = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           redirect_pc_i = $urandom;
            #1;
            n_cmp++; if (count_o > 3'd4) begin n_err++; $display("FAIL rnd_count n%0d: got %0d want <=4", n, count_o); end
            if (redirect_i) begin
                n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL rnd_redir_valid n%0d: got %0b want 0", n, id_valid_o); end
                exp_pc = redirect_pc_i & ~32'd3;
                since_redir = 0;
                quiet = 0;
            end else begin
                if (since_redir < 3) begin
                    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL rnd_latency n%0d: got %0b want 0", n, id_valid_o); end
                end
                if (id_valid_o === 1'b1) begin
                    quiet = 0;
                    n_cmp++; if (id_pc_o !== exp_pc) begin n_err++; $display("FAIL rnd_pc n%0d: got %h want %h", n, id_pc_o, exp_pc); end
                    n_cmp++; if (id_pc_plus4_o !== exp_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4 n%0d: got %h want %h", n, id_pc_plus4_o, exp_pc + 32'd4); end
                    n_cmp++; if (id_inst_o !== mem_word(exp_pc)) begin n_err++; $display("FAIL rnd_inst n%0d: got %h want %h", n, id_inst_o, mem_word(exp_pc)); end
                    if (id_ready_i) begin
                        exp_pc = exp_pc + 32'd4;
                        n_pop++;
                    end
                end else begin
                    quiet++;
                end
                n_cmp++; if (quiet > 3) begin n_err++; $display("FAIL rnd_starve n%0d: got %0d idle cycles want <=3", n, quiet); end
            end
            since_redir++;
            tick();
        end
        redirect_i = 1'b0;
        $display("test_random: %0d instructions delivered", n_pop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_align();
        test_reset_inflight();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
